// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed big-endian byte stream into imem and holds the CPU
// in reset until the image is written. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_boot_loader #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_address,
    output logic [31:0]       imem_data,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [31:0] DEPTH  = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_BYTES,
        S_WRITE,
        S_HOLD,
        S_RUN,
        S_ERR,
        S_CSUM
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [23:0]         asm_q, asm_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                in_ready_q, in_ready_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                xfer;
    logic [15:0]         len_new;

    // in_ready_q always reflects whether state_q accepts bytes, so it alone qualifies a transfer
    assign xfer = in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        hold_cnt_d = '0;
        addr_d     = addr_q;
        data_d     = data_q;
        wren_d     = 1'b0;
        len_new    = {len_q[15:8], in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                    if (len_new == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_HOLD;
`endif
                    end else if (32'(len_new) > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_BYTES;
                    end
                end
            end
            S_BYTES: begin
                if (xfer) begin
                    asm_d      = {asm_q[15:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ in_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        wren_d  = 1'b1;
                        data_d  = {asm_q, in_data};
                        addr_d  = word_cnt_q[ADDR_W-1:0];
                    end
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
                if (32'(word_cnt_d) == 32'(len_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_HOLD;
`endif
                end else begin
                    state_d = S_BYTES;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? S_HOLD : S_ERR;
                end
            end
`endif
            S_HOLD: begin
                if (32'(hold_cnt_q) + 32'd1 >= 32'(HOLD_CYCLES)) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_RUN:   state_d = S_RUN;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_LEN_HI;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe
        in_ready_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                      (state_d == S_BYTES)  || (state_d == S_CSUM);
        cpu_reset_d = (state_d != S_RUN);
        done_d      = (state_d == S_RUN);
        error_d     = (state_d == S_ERR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_LEN_HI;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            asm_q       <= '0;
            hold_cnt_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
            in_ready_q  <= 1'b0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            asm_q       <= asm_d;
            hold_cnt_q  <= hold_cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
            in_ready_q  <= in_ready_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_wren    = wren_q;
    assign imem_address = addr_q;
    assign imem_data    = data_q;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = done_q;
    assign load_error   = error_q;

endmodule
